// File: rtl/mlp_core.sv
// mlp_core: two-layer Q32.32 perceptron, combinational forward pass with on-chip SGD training.
// Latency 1 cycle (registered prediction); no backpressure, a new sample is accepted every clk.
module mlp_core #(
    parameter int inputs            = 2,
    parameter int hidden_layer_size = 2,
    parameter int outputs           = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [63:0] values            [inputs],
    input  logic signed [63:0] expected          [outputs],
    input  logic        [1:0]  hidden_activation,
    input  logic        [1:0]  output_activation,
    input  logic               training,
    input  logic signed [63:0] learning_rate,
    output logic signed [63:0] prediction        [outputs]
);

    localparam logic signed [63:0] ONE         = 64'sh0000_0001_0000_0000;
    localparam logic signed [63:0] HALF        = 64'sh0000_0000_8000_0000;
    localparam logic signed [63:0] NEG_QUARTER = -64'sh0000_0000_4000_0000;
    localparam logic signed [63:0] SMAX        = 64'sh7fff_ffff_ffff_ffff;
    localparam logic signed [63:0] SMIN        = 64'sh8000_0000_0000_0000;
    localparam logic [1:0] ACT_RELU = 2'd1;
    localparam logic [1:0] ACT_SIG  = 2'd2;

    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b);
        logic signed [63:0] s;
        s = a + b;
        if (a[63] == b[63] && s[63] != a[63]) return a[63] ? SMIN : SMAX;
        return s;
    endfunction

    function automatic logic signed [63:0] sat_sub(input logic signed [63:0] a, input logic signed [63:0] b);
        logic signed [63:0] s;
        s = a - b;
        if (a[63] != b[63] && s[63] != a[63]) return a[63] ? SMIN : SMAX;
        return s;
    endfunction

    // Full-width product, rescaled; any bits above the sign in [127:63] mean overflow.
    function automatic logic signed [63:0] fx_mul(input logic signed [63:0] a, input logic signed [63:0] b);
        logic signed [127:0] ae;
        logic signed [127:0] be;
        logic signed [127:0] p;
        ae = {{64{a[63]}}, a};
        be = {{64{b[63]}}, b};
        p  = (ae * be) >>> 32;
        if (p[127:63] != {65{p[127]}}) return p[127] ? SMIN : SMAX;
        return p[63:0];
    endfunction

    function automatic logic signed [63:0] hard_sig(input logic signed [63:0] z);
        logic signed [63:0] t;
        t = (z / 64'sd4) + HALF;
        if (t < 0)   return '0;
        if (t > ONE) return ONE;
        return t;
    endfunction

    function automatic logic signed [63:0] act_f(input logic [1:0] sel, input logic signed [63:0] z);
        case (sel)
            ACT_RELU: return (z > 0) ? z : '0;
            ACT_SIG:  return hard_sig(z);
            default:  return z;
        endcase
    endfunction

    function automatic logic signed [63:0] act_d(input logic [1:0] sel, input logic signed [63:0] z);
        logic signed [63:0] s;
        s = hard_sig(z);
        case (sel)
            ACT_RELU: return (z > 0) ? ONE : '0;
            ACT_SIG:  return fx_mul(s, sat_sub(ONE, s));
            default:  return ONE;
        endcase
    endfunction

    logic signed [63:0] w1 [hidden_layer_size][inputs];
    logic signed [63:0] b1 [hidden_layer_size];
    logic signed [63:0] w2 [outputs][hidden_layer_size];
    logic signed [63:0] b2 [outputs];

    logic signed [63:0] zh    [hidden_layer_size];
    logic signed [63:0] h     [hidden_layer_size];
    logic signed [63:0] d_hid [hidden_layer_size];
    logic signed [63:0] zo    [outputs];
    logic signed [63:0] y     [outputs];
    logic signed [63:0] d_out [outputs];
    logic signed [63:0] acc;

    always_comb begin
        acc   = '0;
        zh    = '{default: '0};
        h     = '{default: '0};
        d_hid = '{default: '0};
        zo    = '{default: '0};
        y     = '{default: '0};
        d_out = '{default: '0};
        for (int j = 0; j < hidden_layer_size; j++) begin
            acc = b1[j];
            for (int i = 0; i < inputs; i++) acc = sat_add(acc, fx_mul(w1[j][i], values[i]));
            zh[j] = acc;
            h[j]  = act_f(hidden_activation, acc);
        end
        for (int k = 0; k < outputs; k++) begin
            acc = b2[k];
            for (int j = 0; j < hidden_layer_size; j++) acc = sat_add(acc, fx_mul(w2[k][j], h[j]));
            zo[k]    = acc;
            y[k]     = act_f(output_activation, acc);
            d_out[k] = fx_mul(sat_sub(y[k], expected[k]), act_d(output_activation, acc));
        end
        // Error is propagated through the pre-update output weights.
        for (int j = 0; j < hidden_layer_size; j++) begin
            acc = '0;
            for (int k = 0; k < outputs; k++) acc = sat_add(acc, fx_mul(w2[k][j], d_out[k]));
            d_hid[j] = fx_mul(act_d(hidden_activation, zh[j]), acc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < outputs; k++) begin
                prediction[k] <= '0;
                b2[k]         <= '0;
                for (int j = 0; j < hidden_layer_size; j++)
                    w2[k][j] <= ((k + j) % 2 == 0) ? HALF : NEG_QUARTER;
            end
            for (int j = 0; j < hidden_layer_size; j++) begin
                b1[j] <= '0;
                for (int i = 0; i < inputs; i++)
                    w1[j][i] <= ((i + j) % 2 == 0) ? HALF : NEG_QUARTER;
            end
        end else begin
            for (int k = 0; k < outputs; k++) prediction[k] <= y[k];
            if (training) begin
                for (int k = 0; k < outputs; k++) begin
                    b2[k] <= sat_sub(b2[k], fx_mul(learning_rate, d_out[k]));
                    for (int j = 0; j < hidden_layer_size; j++)
                        w2[k][j] <= sat_sub(w2[k][j], fx_mul(fx_mul(learning_rate, d_out[k]), h[j]));
                end
                for (int j = 0; j < hidden_layer_size; j++) begin
                    b1[j] <= sat_sub(b1[j], fx_mul(learning_rate, d_hid[j]));
                    for (int i = 0; i < inputs; i++)
                        w1[j][i] <= sat_sub(w1[j][i], fx_mul(fx_mul(learning_rate, d_hid[j]), values[i]));
                end
            end
        end
    end

endmodule

// File: tb/tb_mlp_core.sv
// tb_mlp_core: directed and random stimulus against a wide-integer reference model of the network.
// Model is stepped before each edge with the same inputs the DUT samples.
module tb_mlp_core;

    localparam int NI = 2;
    localparam int NH = 2;
    localparam int NO = 1;
    localparam longint ONE     = 64'sh0000_0001_0000_0000;
    localparam longint HALF    = 64'sh0000_0000_8000_0000;
    localparam longint QUARTER = 64'sh0000_0000_4000_0000;
    localparam longint LR      = 64'sh0000_0000_1999_999A;
    localparam logic signed [127:0] WMAX = 128'sh7fff_ffff_ffff_ffff;
    localparam logic signed [127:0] WMIN = -WMAX - 1;

    logic               clk;
    logic               rst;
    logic signed [63:0] values     [NI];
    logic signed [63:0] expected   [NO];
    logic        [1:0]  hact;
    logic        [1:0]  oact;
    logic               training;
    logic signed [63:0] lr;
    logic signed [63:0] prediction [NO];

    int n_cmp = 0;
    int n_bad = 0;

    longint mw1 [NH][NI];
    longint mb1 [NH];
    longint mw2 [NO][NH];
    longint mb2 [NO];
    longint mpred [NO];

    mlp_core #(.inputs(NI), .hidden_layer_size(NH), .outputs(NO)) dut (
        .clk               (clk),
        .rst               (rst),
        .values            (values),
        .expected          (expected),
        .hidden_activation (hact),
        .output_activation (oact),
        .training          (training),
        .learning_rate     (lr),
        .prediction        (prediction)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic signed [127:0] wide(input longint a);
        logic signed [127:0] r;
        r = a;
        return r;
    endfunction

    function automatic longint clamp(input logic signed [127:0] x);
        if (x > WMAX) return longint'(WMAX[63:0]);
        if (x < WMIN) return longint'(WMIN[63:0]);
        return longint'(x[63:0]);
    endfunction

    function automatic longint m_add(input longint a, input longint b);
        return clamp(wide(a) + wide(b));
    endfunction

    function automatic longint m_sub(input longint a, input longint b);
        return clamp(wide(a) - wide(b));
    endfunction

    function automatic longint m_mul(input longint a, input longint b);
        return clamp((wide(a) * wide(b)) >>> 32);
    endfunction

    function automatic longint m_sig(input longint z);
        logic signed [127:0] t;
        t = wide(z) / 4 + wide(HALF);
        if (t < 0) return 0;
        if (t > wide(ONE)) return ONE;
        return longint'(t[63:0]);
    endfunction

    function automatic longint m_act(input logic [1:0] sel, input longint z);
        if (sel == 2'd1) return (z > 0) ? z : 0;
        if (sel == 2'd2) return m_sig(z);
        return z;
    endfunction

    function automatic longint m_dact(input logic [1:0] sel, input longint z);
        if (sel == 2'd1) return (z > 0) ? ONE : 0;
        if (sel == 2'd2) return m_mul(m_sig(z), m_sub(ONE, m_sig(z)));
        return ONE;
    endfunction

    task automatic model_edge();
        longint zh [NH];
        longint h  [NH];
        longint dh [NH];
        longint zo [NO];
        longint yk [NO];
        longint dk [NO];
        longint s;
        for (int j = 0; j < NH; j++) begin
            s = mb1[j];
            for (int i = 0; i < NI; i++) s = m_add(s, m_mul(mw1[j][i], values[i]));
            zh[j] = s;
            h[j]  = m_act(hact, s);
        end
        for (int k = 0; k < NO; k++) begin
            s = mb2[k];
            for (int j = 0; j < NH; j++) s = m_add(s, m_mul(mw2[k][j], h[j]));
            zo[k] = s;
            yk[k] = m_act(oact, s);
            dk[k] = m_mul(m_sub(yk[k], expected[k]), m_dact(oact, zo[k]));
        end
        for (int j = 0; j < NH; j++) begin
            s = 0;
            for (int k = 0; k < NO; k++) s = m_add(s, m_mul(mw2[k][j], dk[k]));
            dh[j] = m_mul(m_dact(hact, zh[j]), s);
        end
        if (rst) begin
            for (int k = 0; k < NO; k++) begin
                mpred[k] = 0;
                mb2[k]   = 0;
                for (int j = 0; j < NH; j++) mw2[k][j] = ((k + j) % 2 == 0) ? HALF : -QUARTER;
            end
            for (int j = 0; j < NH; j++) begin
                mb1[j] = 0;
                for (int i = 0; i < NI; i++) mw1[j][i] = ((i + j) % 2 == 0) ? HALF : -QUARTER;
            end
        end else begin
            for (int k = 0; k < NO; k++) mpred[k] = yk[k];
            if (training) begin
                for (int k = 0; k < NO; k++) begin
                    mb2[k] = m_sub(mb2[k], m_mul(lr, dk[k]));
                    for (int j = 0; j < NH; j++) mw2[k][j] = m_sub(mw2[k][j], m_mul(m_mul(lr, dk[k]), h[j]));
                end
                for (int j = 0; j < NH; j++) begin
                    mb1[j] = m_sub(mb1[j], m_mul(lr, dh[j]));
                    for (int i = 0; i < NI; i++) mw1[j][i] = m_sub(mw1[j][i], m_mul(m_mul(lr, dh[j]), values[i]));
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vals(input longint a, input longint b);
        values[0] = a;
        values[1] = b;
    endtask

    initial begin
        longint prev;
        longint rv;
        bit     a;
        bit     b;
        rst = 1'b1; training = 1'b0; hact = 2'd0; oact = 2'd0; lr = LR;
        set_vals(0, 0);
        expected[0] = 0;
        #2;

        // Reset, then plain linear forward pass with untouched reset weights.
        tick();
        check("reset_pred", prediction[0], 64'h0);
        rst = 1'b0;
        set_vals(ONE, ONE);
        tick();
        check("lin_fwd", prediction[0], 64'h0000_0000_1000_0000);
        check("lin_model", prediction[0], mpred[0]);

        oact = 2'd2;
        tick();
        check("sig_fwd", prediction[0], 64'h0000_0000_8400_0000);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("sig_hold", prediction[0], 64'h0000_0000_8400_0000);
        end

        // Linear training toward ONE: output must climb every cycle.
        oact = 2'd0; training = 1'b1; expected[0] = ONE;
        tick();
        check("train_first", prediction[0], mpred[0]);
        prev = prediction[0];
        for (int c = 0; c < 5; c++) begin
            tick();
            check("train_up", {63'b0, prediction[0] > prev}, 64'd1);
            check("train_model", prediction[0], mpred[0]);
            prev = prediction[0];
        end

        // Random mix of activations, rates, targets, training and occasional reset.
        for (int c = 0; c < 300; c++) begin
            rst      = ($urandom_range(0, 31) == 0);
            training = $urandom_range(0, 1) == 1;
            hact     = 2'($urandom_range(0, 3));
            oact     = 2'($urandom_range(0, 3));
            lr       = longint'($urandom_range(0, 32'h3000_0000));
            rv       = longint'($signed($urandom)) <<< 3;
            values[0] = rv;
            rv       = longint'($signed($urandom)) <<< 3;
            values[1] = rv;
            rv       = longint'($signed($urandom)) <<< 2;
            expected[0] = rv;
            tick();
            check("rand", prediction[0], mpred[0]);
        end

        // Reset in the middle of training restores the reset-state network.
        rst = 1'b0; training = 1'b1; hact = 2'd1; oact = 2'd2; lr = LR;
        set_vals(ONE, 0); expected[0] = ONE;
        tick();
        check("mid_train", prediction[0], mpred[0]);
        rst = 1'b1;
        tick();
        check("rst_mid", prediction[0], 64'h0);
        rst = 1'b0; training = 1'b0; hact = 2'd0; oact = 2'd0;
        set_vals(ONE, ONE);
        tick();
        check("rst_restore", prediction[0], 64'h0000_0000_1000_0000);

        // Learn AND with ReLU hidden / hard-sigmoid output.
        hact = 2'd1; oact = 2'd2; lr = LR; training = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            a = (n % 2) == 1;
            b = ((n / 2) % 2) == 1;
            set_vals(a ? ONE : 0, b ? ONE : 0);
            expected[0] = (a && b) ? ONE : 0;
            tick();
            check("and_train", prediction[0], mpred[0]);
        end
        training = 1'b0;
        for (int p = 0; p < 4; p++) begin
            a = (p % 2) == 1;
            b = (p / 2) == 1;
            set_vals(a ? ONE : 0, b ? ONE : 0);
            tick();
            check("and_model", prediction[0], mpred[0]);
            check("and_thresh", {63'b0, prediction[0] > HALF}, {63'b0, a && b});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
